// File: rtl/shift_cmd_frontend.sv
// Command front-end for a combinational rotate-type barrel shifter.
// Buffers incoming shift commands in a small FIFO. Presents the head command
// to the external shifter and captures the shifter result in an output register.
//
// Handshake rule (cmd_* and out_*): a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds its payload stable while
// valid is high and ready is low. ready never depends on valid.
module shift_cmd_frontend #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CMD_SHAMT_W = 8,
  localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_data,
  input  logic [CMD_SHAMT_W-1:0] cmd_shamt,
  input  logic                   cmd_dir,
  output logic [WIDTH-1:0]       rot_a,
  output logic [SHAMT_WIDTH-1:0] rot_shamt,
  output logic                   rot_dir,
  input  logic [WIDTH-1:0]       rot_res,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [15:0]            ops_done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = WIDTH + SHAMT_WIDTH + 1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Entry layout: {operand, rotate amount, direction}
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;

  // The upper amount bits are dropped on purpose. Truncating the amount
  // gives a rotation modulo WIDTH.
  generate
    if (CMD_SHAMT_W > SHAMT_WIDTH) begin : g_shamt_hi
      logic unused_shamt_hi;
      assign unused_shamt_hi = ^cmd_shamt[CMD_SHAMT_W-1:SHAMT_WIDTH];
    end
  endgenerate

  // The extra wrap bit tells full apart from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && (!out_valid || out_ready);

  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign rot_a     = empty ? '0 : head[ENTRY_W-1 -: WIDTH];
  assign rot_shamt = empty ? '0 : head[SHAMT_WIDTH:1];
  assign rot_dir   = empty ? 1'b0 : head[0];

  // Command storage: written on push only. The array contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= {cmd_data, cmd_shamt[SHAMT_WIDTH-1:0], cmd_dir};
    end
  end

  // FIFO pointers: each pointer advances on its own handshake and wraps modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Output register captures the shifter result and keeps it until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= rot_res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count of completed output handshakes. The counter wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= '0;
    end else if (out_valid && out_ready) begin
      ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_shift_cmd_frontend.sv
// Bench for shift_cmd_frontend. A behavioural rotate shifter is attached to
// the rot_* port. Results are checked against an arithmetic rotate model
// through an expected queue.
module tb_shift_cmd_frontend;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CSW = 8;
  localparam int SW  = $clog2(W);

  logic           clk;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [W-1:0]   cmd_data;
  logic [CSW-1:0] cmd_shamt;
  logic           cmd_dir;
  logic [W-1:0]   rot_a;
  logic [SW-1:0]  rot_shamt;
  logic           rot_dir;
  logic [W-1:0]   rot_res;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [15:0]    ops_done;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] exp_ops = 16'd0;
  logic        last_push;
  logic        last_hs;

  // Directed commands and the rotate results expected for them.
  logic [W-1:0]   d_data  [5] = '{8'h81, 8'h81, 8'hA5, 8'h01, 8'h80};
  logic [CSW-1:0] d_shamt [5] = '{8'd1, 8'd1, 8'd0, 8'd9, 8'd8};
  logic           d_dir   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0]   d_exp   [5] = '{8'h03, 8'hC0, 8'hA5, 8'h02, 8'h80};

  shift_cmd_frontend #(.WIDTH(W), .DEPTH(D), .CMD_SHAMT_W(CSW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_shamt(cmd_shamt), .cmd_dir(cmd_dir),
    .rot_a(rot_a), .rot_shamt(rot_shamt), .rot_dir(rot_dir),
    .rot_res(rot_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ops_done(ops_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached shifter: moves each bit to its rotated position.
  always_comb begin
    rot_res = '0;
    for (int i = 0; i < W; i++) begin
      int j;
      j = (i + int'(rot_shamt)) % W;
      if (rot_dir) rot_res[i] = rot_a[j];
      else         rot_res[j] = rot_a[i];
    end
  end

  // Reference rotate computed with plain arithmetic on the full command amount.
  function automatic logic [W-1:0] ref_rotate(input logic [W-1:0] d,
                                              input logic [CSW-1:0] s,
                                              input logic dir);
    int k;
    int v;
    int r;
    k = int'(s) % W;
    if (dir) k = (W - k) % W;
    v = int'(d);
    r = ((v << k) | (v >> (W - k))) & ((1 << W) - 1);
    return W'(r);
  endfunction

  // One clock: sample handshakes away from the edge, update the scoreboard,
  // then advance to just after the rising edge.
  task automatic tick();
    logic         held;
    logic [W-1:0] held_data;
    logic [W-1:0] e;
    #1;
    last_push = 1'b0;
    last_hs   = 1'b0;
    held      = 1'b0;
    held_data = '0;
    if (rst) begin
      exp_q.delete();
      exp_ops = 16'd0;
    end else begin
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        last_hs = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: out_data=%h emitted, expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL sb_data: out_data=%h expected=%h", out_data, e);
          end
        end
        exp_ops = exp_ops + 16'd1;
      end
      if (cmd_valid && cmd_ready) begin
        last_push = 1'b1;
        exp_q.push_back(ref_rotate(cmd_data, cmd_shamt, cmd_dir));
      end
    end
    @(posedge clk);
    #1;
    if (held) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data) begin
        errors++;
        $display("FAIL stall_hold: out_valid=%b out_data=%h expected 1/%h", out_valid, out_data, held_data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || ops_done !== 16'd0) begin
      errors++;
      $display("FAIL rst_outputs: out_valid=%b out_data=%h ops_done=%h expected 0/00/0000", out_valid, out_data, ops_done);
    end
    checks++;
    if (rot_a !== '0 || rot_shamt !== '0 || rot_dir !== 1'b0) begin
      errors++;
      $display("FAIL rst_rot_empty: rot_a=%h rot_shamt=%h rot_dir=%b expected zeros", rot_a, rot_shamt, rot_dir);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = d_data[i];
      cmd_shamt = d_shamt[i];
      cmd_dir   = d_dir[i];
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (last_push !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_push: push=%b out_valid=%b expected 1/0", i, last_push, out_valid);
      end
      checks++;
      if (rot_a !== d_data[i] || rot_shamt !== SW'(int'(d_shamt[i]) % W) || rot_dir !== d_dir[i]) begin
        errors++;
        $display("FAIL dir%0d_rot_drive: rot_a=%h rot_shamt=%0d rot_dir=%b expected %h/%0d/%b",
                 i, rot_a, rot_shamt, rot_dir, d_data[i], int'(d_shamt[i]) % W, d_dir[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d_exp[i]) begin
        errors++;
        $display("FAIL dir%0d_result: out_valid=%b out_data=%h expected 1/%h", i, out_valid, out_data, d_exp[i]);
      end
      tick();
      checks++;
      if (last_hs !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_consume: hs=%b out_valid=%b expected 1/0", i, last_hs, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted  = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = W'($urandom);
      cmd_shamt = CSW'($urandom);
      cmd_dir   = 1'($urandom);
      tick();
      if (last_push) accepted++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (accepted != D + 1) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, D + 1); end
    checks++;
    if (cmd_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: cmd_ready=%b out_valid=%b expected 0/1", cmd_ready, out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (last_hs !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_pop: hs=%b cmd_ready=%b expected 1/1", last_hs, cmd_ready);
    end
    for (int i = 0; i < D; i++) begin
      tick();
      checks++;
      if (last_hs !== 1'b1) begin errors++; $display("FAIL bp_drain%0d: hs=%b expected 1", i, last_hs); end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: pending=%0d out_valid=%b expected 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_stream();
    int issued;
    int got;
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issued = 0;
    got    = 0;
    n      = 0;
    cmd_data  = W'($urandom);
    cmd_shamt = CSW'($urandom);
    cmd_dir   = 1'($urandom);
    while (got < 20 && n < 1000) begin
      cmd_valid = (issued < 20) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (last_push) begin
        issued++;
        cmd_data  = W'($urandom);
        cmd_shamt = CSW'($urandom);
        cmd_dir   = 1'($urandom);
      end
      if (last_hs) got++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (got != 20) begin errors++; $display("FAIL stream_count: got %0d results expected 20 (cycle budget)", got); end
    checks++;
    if (ops_done !== 16'd20) begin errors++; $display("FAIL stream_ops_done: got %0d expected 20", ops_done); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = W'($urandom);
      cmd_shamt = CSW'($urandom);
      cmd_dir   = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pending: out_valid=%b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst: got %b expected 0", cmd_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || ops_done !== 16'd0) begin
      errors++;
      $display("FAIL rm_cleared: out_valid=%b out_data=%h ops_done=%h expected 0/00/0000", out_valid, out_data, ops_done);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after: got %b expected 1", cmd_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d: out_valid=%b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_ops != 16'hFFFF && n < 70000) begin
      cmd_valid = 1'b1;
      cmd_data  = W'($urandom);
      cmd_shamt = CSW'($urandom);
      cmd_dir   = 1'($urandom);
      tick();
      n++;
    end
    checks++;
    if (ops_done !== 16'hFFFF) begin errors++; $display("FAIL wrap_top: ops_done=%h expected ffff", ops_done); end
    tick();
    checks++;
    if (last_hs !== 1'b1 || ops_done !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: hs=%b ops_done=%h expected 1/0000", last_hs, ops_done);
    end
    tick();
    checks++;
    if (ops_done !== 16'h0001) begin errors++; $display("FAIL wrap_continue: ops_done=%h expected 0001", ops_done); end
    cmd_valid = 1'b0;
    for (int i = 0; i < D + 4; i++) tick();
    checks++;
    if (exp_q.size() != 0 || ops_done !== exp_ops) begin
      errors++;
      $display("FAIL wrap_drain: pending=%0d ops_done=%h expected 0/%h", exp_q.size(), ops_done, exp_ops);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_shamt = '0;
    cmd_dir   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
